// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes async reset requests, stretches reset, then releases
// channels in ascending order GAP cycles apart. done is high once every channel is released.
module rst_seq #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned STRETCH = 16,
    parameter int unsigned GAP     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_CH-1:0]  rst_out,
    output logic               done,
    output logic [NUM_REQ-1:0] cause
);

    localparam int unsigned CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StHold, StStretch, StRelease, StRun} state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_CH-1:0]               rst_out_q, rst_out_d;
    logic [NUM_REQ-1:0]              cause_q, cause_d;
    logic                            done_q, done_d;
    logic [DEPTH-1:0][NUM_REQ-1:0]   sync_q;
    logic [NUM_REQ-1:0]              req_sync;

    assign req_sync = sync_q[DEPTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        cause_d   = cause_q;
        case (state_q)
            StHold: begin
                rst_out_d = '1;
                cnt_d     = '0;
                cause_d   = cause_q | req_sync;
                if (req_sync == '0) begin
                    state_d = StStretch;
                end
            end
            StStretch: begin
                rst_out_d = '1;
                if (req_sync != '0) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    cause_d = req_sync;
                end else if (cnt_q == CNT_W'(STRETCH - 1)) begin
                    state_d      = StRelease;
                    cnt_d        = '0;
                    rst_out_d[0] = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRelease: begin
                if (req_sync != '0) begin
                    state_d   = StHold;
                    cnt_d     = '0;
                    rst_out_d = '1;
                    cause_d   = req_sync;
                end else if (!rst_out_q[NUM_CH-1]) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(GAP - 1)) begin
                    // Shifting ones upward clears the next channel, keeping release ascending.
                    rst_out_d = rst_out_q << 1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                rst_out_d = '0;
                cnt_d     = '0;
                if (req_sync != '0) begin
                    state_d   = StHold;
                    rst_out_d = '1;
                    cause_d   = req_sync;
                end
            end
            default: begin
                state_d   = StHold;
                cnt_d     = '0;
                rst_out_d = '1;
            end
        endcase
        done_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StStretch;
            cnt_q     <= '0;
            rst_out_q <= '1;
            cause_q   <= '0;
            done_q    <= 1'b0;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            cause_q   <= cause_d;
            done_q    <= done_d;
            sync_q    <= {sync_q[DEPTH-2:0], req_i};
        end
    end

    assign rst_out = rst_out_q;
    assign done    = done_q;
    assign cause   = cause_q;

endmodule
